// File: rtl/apb_master_pkg.sv
`default_nettype none
// ============================================================================
// apb_master_pkg : shared FSM states and default command payload for the
//                  queued APB requester.
// Revision: 1.0
// ============================================================================
package apb_master_pkg;

  localparam int c_ADDR_W = 32;
  localparam int c_DATA_W = 32;
  localparam int c_STRB_W = c_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic                write;
    logic [c_ADDR_W-1:0] addr;
    logic [c_DATA_W-1:0] wdata;
    logic [c_STRB_W-1:0] strb;
  } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// apb_cmd_fifo : power-of-two command FIFO, pointers carry an extra wrap bit.
// Revision: 1.0
// ============================================================================
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = apb_cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int               c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_PTR_ONE = (c_PTR_W + 1)'(1);

  T                 r_mem [DEPTH];
  logic [c_PTR_W:0] r_wr_ptr;
  logic [c_PTR_W:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Same index with differing wrap bits means every slot is occupied.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                   (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/apb_master_queued.sv
`default_nettype none
// ============================================================================
// apb_master_queued : FIFO-buffered APB3/APB4 requester with wait states.
//   Define APB_MASTER_TIMEOUT_EN to abort transfers stuck in ACCESS.
// Revision: 1.0
// ============================================================================
module apb_master_queued
  import apb_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int c_STRB_W = DATA_W / 8;

  typedef struct packed {
    logic                write;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [c_STRB_W-1:0] strb;
  } cmd_t;

  cmd_t   w_push_cmd;
  cmd_t   w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_pop;
  logic   w_timeout;
  state_e r_state;

  assign w_push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, strb: cmd_strb};
  assign cmd_ready  = !w_full;
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == ACCESS) && PREADY));

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_cmd_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .i_push  (cmd_valid),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;

  // Counts completed ACCESS cycles with PREADY low; the current one is the last.
  assign w_timeout = (r_state == ACCESS) && !PREADY && (r_wait_cnt == c_CNT_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wait_cnt <= '0;
    end else if (w_pop) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ACCESS) && !PREADY) begin
      r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
    end
  end
`else
  // Timeout disabled: ACCESS waits on PREADY indefinitely.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (w_pop) begin
      PWRITE <= w_head.write;
      PADDR  <= w_head.addr;
      PWDATA <= w_head.wdata;
      PSTRB  <= w_head.write ? w_head.strb : '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            PENABLE   <= 1'b0;
            if (!w_empty) begin
              r_state <= SETUP;
            end else begin
              PSEL    <= 1'b0;
              r_state <= IDLE;
            end
          end else if (w_timeout) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
